// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcodes, branch funct3 codes
// and the iterative-multiplier state encoding.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_PASS = 4'b1011;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: bit 0 is folded in on start,
// the remaining bits take one cycle each in BUSY.
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam logic [5:0] LAST = 6'(DATA_WIDTH - 2);

  mul_state_t state, state_n;
  logic [5:0] cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = BUSY;
      BUSY:    if (cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (state == IDLE && start) begin
      cnt  <= '0;
      acc  <= b[0] ? a : '0;
      a_sh <= a << 1;
      b_sh <= b >> 1;
    end else if (state == BUSY) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 6'd1;
    end
  end

  assign busy    = (state == BUSY);
  assign done    = (state == DONE);
  assign product = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: forwarding, ALU, branch resolve,
// iterative multiply and the E->M pipeline register.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidE,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  JalrE,
  input  logic                  BranchE,
  input  logic [2:0]            BranchTypeE,
  input  logic [3:0]            ALUControlE,
  input  logic                  ALUSrcAE,
  input  logic                  ALUSrcBE,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] ImmExtE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PC_PlusE,
  input  logic [4:0]            RdE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  StallE,
  output logic                  RegWriteM,
  output logic [1:0]            ResultSrcM,
  output logic                  MemWriteM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PC_PlusM,
  output logic [4:0]            RdM
);

  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] src_a, src_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] jalr_tgt;
  logic [DATA_WIDTH-1:0] mul_prod;
  logic                  br_take;
  logic                  mul_start, mul_busy, mul_done;

  always_comb begin
    unique case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = RD1E;
    endcase
  end

  always_comb begin
    unique case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_a = ALUSrcAE ? PCE : fwd_a;
  assign src_b = ALUSrcBE ? ImmExtE : fwd_b;

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}},
                           $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_a << src_b[4:0];
      ALU_SRL:  alu_res = src_a >> src_b[4:0];
      ALU_SRA:  alu_res = $signed(src_a) >>> src_b[4:0];
      ALU_MUL:  alu_res = mul_done ? mul_prod : '0;
      ALU_PASS: alu_res = src_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (BranchTypeE)
      BR_EQ:   br_take = (fwd_a == fwd_b);
      BR_NE:   br_take = (fwd_a != fwd_b);
      BR_LT:   br_take = ($signed(fwd_a) < $signed(fwd_b));
      BR_GE:   br_take = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_take = (fwd_a < fwd_b);
      BR_GEU:  br_take = (fwd_a >= fwd_b);
      default: br_take = 1'b0;
    endcase
  end

  assign jalr_tgt  = fwd_a + ImmExtE;
  assign PCTargetE = JalrE ? {jalr_tgt[DATA_WIDTH-1:1], 1'b0}
                           : PCE + ImmExtE;
  assign PCSrcE    = ValidE && !StallE &&
                     (JumpE || (BranchE && br_take));

  // Gated by rst_n so an in-flight MUL releases the stall at once.
  assign mul_start = rst_n && ValidE && (ALUControlE == ALU_MUL) &&
                     !mul_busy && !mul_done;
  assign StallE    = mul_start || mul_busy;

  seq_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (src_a),
    .b      (src_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= '0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PC_PlusM   <= '0;
      RdM        <= '0;
    end else if (StallE) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
    end else begin
      RegWriteM  <= RegWriteE & ValidE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE & ValidE;
      ALUResultM <= alu_res;
      WriteDataM <= fwd_b;
      PC_PlusM   <= PC_PlusE;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized scoreboard bench for ex_mem_stage against
// an arithmetic reference model.
module tb_ex_mem_stage;

  localparam int W = 32;

  typedef struct packed {
    logic        valid, regw, memw, jump, jalr, branch, srca, srcb;
    logic [1:0]  rsrc, fa, fb;
    logic [2:0]  bt;
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, pc, pcp, resw;
    logic [4:0]  rd;
  } instr_t;

  typedef struct packed {
    logic        regw, memw, chk_alu;
    logic [1:0]  rsrc;
    logic [31:0] alu, wdata, pcp;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ValidE, RegWriteE, MemWriteE, JumpE, JalrE, BranchE;
  logic ALUSrcAE, ALUSrcBE;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0] BranchTypeE;
  logic [3:0] ALUControlE;
  logic [W-1:0] RD1E, RD2E, ImmExtE, PCE, PC_PlusE, ResultW;
  logic [4:0] RdE;
  logic PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [W-1:0] PCTargetE, ALUResultM, WriteDataM, PC_PlusM;
  logic [1:0] ResultSrcM;
  logic [4:0] RdM;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_alu = '0;
  bit m_known = 1'b1;
  bit ovr_alu_en = 1'b0;
  logic [31:0] ovr_alu;
  bit ovr_pc_en = 1'b0;
  logic ovr_pcsrc;
  logic [31:0] ovr_tgt;

  ex_mem_stage #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .JalrE(JalrE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PC_PlusE(PC_PlusE), .RdE(RdE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .StallE(StallE), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PC_PlusM(PC_PlusM), .RdM(RdM)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  function automatic logic [31:0] alu_ref(logic [3:0] op,
                                          logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return 32'($signed(a) >>> b[4:0]);
      4'd10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(logic [2:0] bt, logic [31:0] a,
                                  logic [31:0] b);
    case (bt)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    t = $urandom();
    t.valid = ($urandom_range(0, 7) != 0);
    t.regw = 1'($urandom()); t.memw = 1'($urandom());
    t.jump = ($urandom_range(0, 5) == 0); t.jalr = 1'($urandom());
    t.branch = 1'($urandom()); t.srca = ($urandom_range(0, 3) == 0);
    t.srcb = 1'($urandom()); t.rsrc = 2'($urandom());
    t.fa = 2'($urandom()); t.fb = 2'($urandom());
    t.bt = 3'($urandom()); t.rd = 5'($urandom());
    t.op = ($urandom_range(0, 9) == 0) ? 4'd10 : 4'($urandom());
    t.rd1 = rnd_val(); t.rd2 = rnd_val(); t.imm = rnd_val();
    t.pc = $urandom(); t.pcp = $urandom(); t.resw = rnd_val();
    return t;
  endfunction

  task automatic drive(input instr_t t);
    ValidE = t.valid; RegWriteE = t.regw; MemWriteE = t.memw;
    JumpE = t.jump; JalrE = t.jalr; BranchE = t.branch;
    ALUSrcAE = t.srca; ALUSrcBE = t.srcb; ResultSrcE = t.rsrc;
    ForwardAE = t.fa; ForwardBE = t.fb; BranchTypeE = t.bt;
    ALUControlE = t.op; RD1E = t.rd1; RD2E = t.rd2; ImmExtE = t.imm;
    PCE = t.pc; PC_PlusE = t.pcp; ResultW = t.resw; RdE = t.rd;
  endtask

  function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] rd,
                                      logic [31:0] w);
    case (sel)
      2'b01: return w;
      2'b10: return m_alu;
      default: return rd;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the capture edge.
  task automatic issue(input instr_t t_in);
    instr_t t;
    exp_t e;
    logic [31:0] fa, fb, sa, sbv;
    logic want_pc;
    logic [31:0] want_tgt;
    bit is_mul;
    int stalls;
    t = t_in;
    if (!m_known && t.fa == 2'b10) t.fa = 2'b00;
    if (!m_known && t.fb == 2'b10) t.fb = 2'b00;
    drive(t);
    rst_n = 1'b1;
    fa = fwd(t.fa, t.rd1, t.resw);
    fb = fwd(t.fb, t.rd2, t.resw);
    sa = t.srca ? t.pc : fa;
    sbv = t.srcb ? t.imm : fb;
    is_mul = t.valid && t.op == 4'd10;
    e.regw = t.regw & t.valid;
    e.memw = t.memw & t.valid;
    e.chk_alu = !(t.op == 4'd10 && !t.valid);
    e.rsrc = t.rsrc;
    e.alu = ovr_alu_en ? ovr_alu : alu_ref(t.op, sa, sbv);
    e.wdata = fb;
    e.pcp = t.pcp;
    e.rd = t.rd;
    sb.push_back(e);
    want_pc = t.valid & (t.jump | (t.branch & br_ref(t.bt, fa, fb)));
    want_tgt = t.jalr ? ((fa + t.imm) & ~32'h1) : t.pc + t.imm;
    if (ovr_pc_en) begin
      want_pc = ovr_pcsrc;
      want_tgt = ovr_tgt;
    end
    stalls = 0;
    @(negedge clk);
    while (StallE === 1'b1 && stalls < 64) begin
      stalls++;
      chk("pcsrc_in_stall", 64'(PCSrcE), 64'd0);
      @(negedge clk);
    end
    chk("stall_cycles", 64'(stalls), is_mul ? 64'(W) : 64'd0);
    chk("pcsrc", 64'(PCSrcE), 64'(want_pc));
    chk("pctarget", 64'(PCTargetE), 64'(want_tgt));
    m_known = e.chk_alu;
    if (e.chk_alu) m_alu = e.alu;
    ovr_alu_en = 1'b0;
    ovr_pc_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic mul_abort(input instr_t t);
    drive(t);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("abort_pre_stall", 64'(StallE), 64'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_stall", 64'(StallE), 64'd0);
    chk("abort_regw", 64'(RegWriteM), 64'd0);
    chk("abort_alu", 64'(ALUResultM), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    m_alu = '0;
    m_known = 1'b1;
  endtask

  // Monitor: pops one expectation per stall-free capture edge.
  initial begin : monitor
    exp_t e, last;
    bit cap;
    cap = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_m_zero", {RegWriteM, MemWriteM, ResultSrcM, RdM,
            ALUResultM}, 64'd0);
        chk("rst_m_data", {WriteDataM, PC_PlusM}, 64'd0);
        chk("rst_stall", 64'(StallE), 64'd0);
        last = '0;
        last.chk_alu = 1'b1;
      end else if (cap) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("regwrite_m", 64'(RegWriteM), 64'(e.regw));
          chk("memwrite_m", 64'(MemWriteM), 64'(e.memw));
          chk("resultsrc_m", 64'(ResultSrcM), 64'(e.rsrc));
          if (e.chk_alu) chk("aluresult_m", 64'(ALUResultM), 64'(e.alu));
          chk("writedata_m", 64'(WriteDataM), 64'(e.wdata));
          chk("pcplus_m", 64'(PC_PlusM), 64'(e.pcp));
          chk("rd_m", 64'(RdM), 64'(e.rd));
          last = e;
        end
      end else begin
        chk("bubble_regw", 64'(RegWriteM), 64'd0);
        chk("bubble_memw", 64'(MemWriteM), 64'd0);
        if (last.chk_alu)
          chk("bubble_alu_hold", 64'(ALUResultM), 64'(last.alu));
        chk("bubble_hold", {PC_PlusM, WriteDataM},
            {last.pcp, last.wdata});
        chk("bubble_rd_hold", 64'({ResultSrcM, RdM}),
            64'({last.rsrc, last.rd}));
      end
      cap = rst_n && !StallE;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    instr_t t;
    t = rnd_instr();
    t.valid = 1'b1;
    t.op = 4'd10;
    drive(t);
    #1;
    chk("rst_stall_mul_in", 64'(StallE), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    t = '0; t.valid = 1; t.regw = 1; t.rd1 = 3; t.rd2 = 4; t.rd = 5'd7;
    ovr_alu_en = 1; ovr_alu = 32'd7;
    issue(t);

    t = '0; t.valid = 1; t.regw = 1; t.rd1 = 2; t.rd2 = 3;
    ovr_alu_en = 1; ovr_alu = 32'd5;
    issue(t);
    t = '0; t.valid = 1; t.regw = 1; t.op = 4'd1; t.fa = 2'b10;
    t.fb = 2'b01; t.resw = 32'd9; t.rd1 = 32'h55; t.rd2 = 32'h66;
    ovr_alu_en = 1; ovr_alu = 32'hFFFF_FFFC;
    issue(t);

    t = '0; t.valid = 1; t.branch = 1; t.bt = 3'b100;
    t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1; t.pc = 32'h100; t.imm = 32'h40;
    ovr_pc_en = 1; ovr_pcsrc = 1; ovr_tgt = 32'h140;
    issue(t);
    t.bt = 3'b110;
    ovr_pc_en = 1; ovr_pcsrc = 0; ovr_tgt = 32'h140;
    issue(t);

    t = '0; t.valid = 1; t.jump = 1; t.jalr = 1; t.regw = 1;
    t.rd1 = 32'h1001; t.imm = 32'd4; t.pc = 32'h2000;
    ovr_pc_en = 1; ovr_pcsrc = 1; ovr_tgt = 32'h1004;
    issue(t);

    t = '0; t.valid = 1; t.regw = 1; t.op = 4'd10;
    t.rd1 = 32'h0001_0003; t.rd2 = 32'h0002_0005; t.rd = 5'd9;
    ovr_alu_en = 1; ovr_alu = 32'h000B_000F;
    issue(t);

    for (int i = 0; i < 2; i++) begin
      t = rnd_instr(); t.valid = 1; t.op = 4'd10;
      issue(t);
    end

    t = rnd_instr(); t.valid = 0; t.op = 4'd10;
    issue(t);

    t = rnd_instr(); t.valid = 1; t.op = 4'd10; t.regw = 1;
    mul_abort(t);
    t = '0; t.valid = 1; t.regw = 1; t.rd1 = 32'd10; t.rd2 = 32'd20;
    issue(t);
    t = rnd_instr(); t.valid = 1; t.op = 4'd10;
    issue(t);

    for (int i = 0; i < 300; i++) issue(rnd_instr());

    @(negedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have E-stage control inputs, each 1 bit unless stated:
- ValidE: instruction valid, 0 = bubble.
- RegWriteE.
- ResultSrcE, 2 bits.
- MemWriteE.
- JumpE.
- JalrE.
- BranchE.
- BranchTypeE, 3 bits (funct3).
- ALUControlE, 4 bits.
- ALUSrcAE.
- ALUSrcBE.
REQ-005 The block SHALL have E-stage data inputs RD1E, RD2E, ImmExtE, PCE and PC_PlusE, each DATA_WIDTH bits, and RdE, 5 bits.
REQ-006 The block SHALL have forwarding inputs ForwardAE and ForwardBE, 2 bits each, and ResultW, DATA_WIDTH bits.
REQ-007 The block SHALL have outputs PCSrcE, 1 bit (redirect fetch), PCTargetE, DATA_WIDTH bits, and StallE, 1 bit (multiplier busy; hold F/D/E).
REQ-008 The block SHALL have M-stage outputs RegWriteM, ResultSrcM (2 bits), MemWriteM, ALUResultM, WriteDataM, PC_PlusM and RdM (5 bits).

Function
REQ-009 Operand forwarding SHALL select by Forward*E: 00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE.
REQ-010 SrcA SHALL be PCE when ALUSrcAE=1, otherwise forwarded A; SrcB SHALL be ImmExtE when ALUSrcBE=1, otherwise forwarded B.
REQ-011 ALUControlE encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
- 0100 XOR, 0101 SLT, 0110 SLTU.
- 0111 SLL, 1000 SRL, 1001 SRA (shift amount = SrcB[4:0]).
- 1010 MUL (low DATA_WIDTH bits, multi-cycle).
- 1011 pass SrcB.
- Others: result 0.
REQ-012 All arithmetic SHALL wrap modulo 2^DATA_WIDTH with no overflow flag.
REQ-013 Branch condition on forwarded A/B SHALL be:
- 000 eq, 001 ne.
- 100 signed lt, 101 signed ge.
- 110 unsigned lt, 111 unsigned ge.
- Others: false.
REQ-014 PCSrcE SHALL equal ValidE & (JumpE | (BranchE & condition)), combinationally, and SHALL be 0 while StallE=1.
REQ-015 PCTargetE SHALL be (forwarded A + ImmExtE) with bit 0 cleared when JalrE=1, otherwise PCE + ImmExtE.
REQ-016 The multiplier FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 From IDLE, ValidE with ALUControlE=1010 SHALL latch both operands, clear the 6-bit counter and enter BUSY next edge; StallE SHALL be 1 combinationally in that first cycle.
REQ-018 BUSY SHALL perform one shift-add step per cycle with StallE=1, and SHALL enter DONE when the counter reaches DATA_WIDTH-1.
REQ-019 DONE SHALL drive StallE=0 and the product as the ALU result for one cycle, then return to IDLE.
REQ-020 Total MUL occupancy of the E stage SHALL be DATA_WIDTH+1 cycles, and E inputs are held stable by upstream during StallE=1.
REQ-021 A MUL issued in IDLE with ValidE=0 SHALL be ignored.
REQ-022 Back-to-back MULs SHALL each incur the full latency.
REQ-023 On each rising edge with StallE=0, the M register SHALL capture:
- RegWriteE&ValidE and MemWriteE&ValidE.
- ResultSrcE, ALU result, forwarded B as WriteDataM, PC_PlusE and RdE.
REQ-024 On each edge with StallE=1, the M register SHALL load a bubble: RegWriteM=0, MemWriteM=0, all other M outputs unchanged.
REQ-025 Latency E→M for non-MUL instructions SHALL be exactly one cycle.

Reset
REQ-026 While rst_n=0, all M outputs SHALL be 0, the FSM SHALL be IDLE, and the counter and operand registers SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-MUL SHALL abort the multiply, with StallE=0 immediately after assertion.
REQ-028 The first edge after rst_n deasserts SHALL behave as a normal IDLE cycle.

Structure
REQ-029 The ALU opcode constants, branch-type constants and the multiplier state enum SHALL live in shared package cpu_pkg.
REQ-030 The iterative multiplier SHALL be a sub-module named seq_multiplier, with start/busy/done handshake and product output.
REQ-031 The ALU and branch compare SHALL be combinational within ex_mem_stage.

Verification
REQ-032 Reset scenario: rst_n=0 with random inputs SHALL give all M outputs 0 and StallE=0; rst_n rising SHALL then pass ADD 3+4 to ALUResultM=7 after 1 edge.
REQ-033 Forwarding scenario: ForwardAE=10 with ALUResultM=5, ForwardBE=01 with ResultW=9, SUB SHALL give ALUResultM=0xFFFFFFFC.
REQ-034 Branch scenario: BLT with A=0xFFFFFFFF, B=1 SHALL give PCSrcE=1, PCTargetE=PCE+ImmExtE; BLTU with the same operands SHALL give PCSrcE=0.
REQ-035 JALR scenario: A=0x1001, Imm=4 SHALL give PCTargetE=0x1004 and PCSrcE=1.
REQ-036 MUL scenario: 0x00010003 × 0x00020005 SHALL hold StallE=1 for 32 cycles and give ALUResultM=0x000B000F on edge 33, with RegWriteM=0 during the stall.
REQ-037 Reset-abort scenario: rst_n pulsed at cycle 10 of a MUL SHALL give StallE=0 and the FSM in IDLE, with no stale product written.
